instr_fetch: RTL and testbench
==============================

Name: instr_fetch

Overview:
- Instruction-fetch control stage directly downstream of the PC register, which holds the current fetch address and provides a write-enabled address input.
- Reads the current PC, runs a request/acknowledge read on the instruction-memory port, latches the returned word into IR, and hands IR to decode with a valid/take handshake.
- Drives the PC register's next address and write enable: sequential PC+4, or a redirect target for branch, jump or exception.
- Non-pipelined, multicycle: at most one fetch outstanding.

Parameters:
- TIMEOUT_CYCLES, 8'd16: number of consecutive un-acknowledged request cycles before a bus error is raised. 0 disables the timeout. Maximum 255.

Ports:
- CLK_I  in  1  system clock; all state changes on the rising edge.
- Reset_I  in  1  reset; synchronous and active-low.
- PC_I  in  32  current PC, from the PC register output.
- IMemAddr_O  out  32  fetch address; equals PC_I combinationally.
- IMemReq_O  out  1  read request; combinational from state and PC_I.
- IMemAck_I  in  1  data valid this cycle; ignored unless IMemReq_O=1.
- IMemData_I  in  32  instruction word; sampled when IMemReq_O and IMemAck_I are both 1.
- IR_O  out  32  latched instruction register.
- PCPlus4_O  out  32  latched address of the IR instruction plus 4.
- IRValid_O  out  1  IR holds an instruction not yet consumed.
- IRTake_I  in  1  decode consumes IR this cycle.
- Redirect_I  in  1  branch, jump or exception redirect request.
- RedirectAddr_I  in  32  redirect target.
- NPC_O  out  32  next PC, to the PC register address input.
- PCWrite_O  out  1  PC write enable, to the PC register.
- AdEL_O  out  1  misaligned-fetch fault; sticky.
- BusErr_O  out  1  fetch-timeout fault; sticky.

Behaviour:
- Reset (Reset_I=0 at a rising edge):
  - state=IDLE.
  - IR_O=0, PCPlus4_O=0, IRValid_O=0, AdEL_O=0, BusErr_O=0, timeout counter=0.
  - Reset asserted mid-fetch abandons the fetch; no PCWrite_O pulse is issued.
- States: IDLE, FETCH, HOLD, FAULT.
- IDLE: outputs inactive; moves to FETCH at the next edge.
- FETCH:
  - If PC_I[1:0]≠0: IMemReq_O=0, AdEL_O←1, state←FAULT.
  - Otherwise: IMemReq_O=1 and IMemAddr_O=PC_I.
  - On IMemAck_I=1, at the same edge: IR_O←IMemData_I, PCPlus4_O←PC_I+4, IRValid_O←1, counter←0, state←HOLD.
  - In the ack cycle, PCWrite_O=1 and NPC_O=PC_I+4 combinationally, so the PC register updates at that same edge.
  - PC+4 is modulo 2^32: 0xFFFFFFFC → 0x00000000.
  - Each cycle without ack increments the counter. When the counter would reach TIMEOUT_CYCLES (and TIMEOUT_CYCLES≠0): BusErr_O←1, state←FAULT, IMemReq_O=0 in the following cycle.
- HOLD:
  - IMemReq_O=0 and IRValid_O=1.
  - On IRTake_I=1: IRValid_O←0, state←FETCH.
  - The minimum fetch-to-fetch interval is 2 cycles (ack cycle, then take cycle).
- FAULT:
  - IMemReq_O=0, PCWrite_O=0; AdEL_O and BusErr_O hold their values.
  - Left only by Redirect_I.
- Redirect_I=1 (any state except during reset; highest priority):
  - Combinationally: PCWrite_O=1, NPC_O=RedirectAddr_I.
  - At the edge: IRValid_O←0, AdEL_O←0, BusErr_O←0, counter←0, state←FETCH.
  - An ack in the same cycle is discarded; IR_O and PCPlus4_O keep their old values.
  - An IRTake_I in the same cycle is ignored.
  - IMemReq_O still follows the FETCH rule in that cycle. The slave must treat a request as abandonable and hold no outstanding state.
- PCWrite_O is 0 in every case not listed above. NPC_O is don't-care when PCWrite_O=0 and is driven as PC_I+4.
- IR_O and PCPlus4_O change only on an accepted ack.

Test Plan:
- Reset held 3 cycles with PC_I=0xBFC00000, then released; ack 2 cycles after the request rises with data 0x3C1DA000. Required: IMemReq_O=1 from the first cycle after IDLE; PCWrite_O=1 only in the ack cycle with NPC_O=0xBFC00004; next cycle IR_O=0x3C1DA000, PCPlus4_O=0xBFC00004, IRValid_O=1.
- Decode holds IRTake_I=0 for 5 cycles, then 1. Required: IRValid_O stays 1, IMemReq_O stays 0 and IR_O is stable throughout; FETCH resumes the cycle after the take.
- PC_I=0xBFC00002 in FETCH. Required: IMemReq_O=0, AdEL_O=1 next edge, state FAULT. Then Redirect_I=1 with RedirectAddr_I=0xBFC00380. Required: PCWrite_O=1, NPC_O=0xBFC00380, AdEL_O=0 next edge, fetch resumes.
- TIMEOUT_CYCLES=4, no ack. Required: IMemReq_O=1 for exactly 4 cycles, then BusErr_O=1, IMemReq_O=0, no PCWrite_O pulse.
- Redirect_I=1 (target 0x80000180) in the same cycle as IMemAck_I=1 (data 0xDEADBEEF). Required: NPC_O=0x80000180, IR_O unchanged, IRValid_O=0, next fetch address 0x80000180.
- Reset_I=0 asserted in the middle of a FETCH wait. Required: all outputs return to reset values at that edge, and no stale ack is latched afterwards.

Source files
------------

// File: rtl/instr_fetch.sv
// Instruction-fetch control: one outstanding req/ack read per instruction, IR hand-off to decode,
// PC register update (sequential or redirect) and sticky misalignment / timeout faults.
module instr_fetch #(
  parameter logic [7:0] TIMEOUT_CYCLES = 8'd16
) (
  input  logic        CLK_I,
  input  logic        Reset_I,
  input  logic [31:0] PC_I,
  output logic [31:0] IMemAddr_O,
  output logic        IMemReq_O,
  input  logic        IMemAck_I,
  input  logic [31:0] IMemData_I,
  output logic [31:0] IR_O,
  output logic [31:0] PCPlus4_O,
  output logic        IRValid_O,
  input  logic        IRTake_I,
  input  logic        Redirect_I,
  input  logic [31:0] RedirectAddr_I,
  output logic [31:0] NPC_O,
  output logic        PCWrite_O,
  output logic        AdEL_O,
  output logic        BusErr_O
);

  typedef enum logic [1:0] {IDLE, FETCH, HOLD, FAULT} state_t;

  state_t      state, state_nxt;
  logic [7:0]  tmo_cnt, tmo_cnt_nxt;
  logic [31:0] pc_plus4;
  logic        aligned;
  logic        accept;
  logic        take;
  logic        adel_set;
  logic        buserr_set;

  assign pc_plus4   = PC_I + 32'd4;
  assign aligned    = (PC_I[1:0] == 2'b00);
  assign IMemAddr_O = PC_I;

  always_comb begin
    state_nxt   = state;
    tmo_cnt_nxt = tmo_cnt;
    IMemReq_O   = 1'b0;
    PCWrite_O   = 1'b0;
    NPC_O       = pc_plus4;
    accept      = 1'b0;
    take        = 1'b0;
    adel_set    = 1'b0;
    buserr_set  = 1'b0;

    case (state)
      IDLE: state_nxt = FETCH;
      FETCH: begin
        if (!aligned) begin
          adel_set  = 1'b1;
          state_nxt = FAULT;
        end else begin
          IMemReq_O = 1'b1;
          if (IMemAck_I) begin
            accept      = 1'b1;
            PCWrite_O   = 1'b1;
            tmo_cnt_nxt = 8'd0;
            state_nxt   = HOLD;
          end else if (TIMEOUT_CYCLES != 8'd0) begin
            if (tmo_cnt + 8'd1 == TIMEOUT_CYCLES) begin
              buserr_set  = 1'b1;
              tmo_cnt_nxt = 8'd0;
              state_nxt   = FAULT;
            end else begin
              tmo_cnt_nxt = tmo_cnt + 8'd1;
            end
          end
        end
      end
      HOLD: begin
        if (IRTake_I) begin
          take      = 1'b1;
          state_nxt = FETCH;
        end
      end
      FAULT: state_nxt = FAULT;
      default: state_nxt = IDLE;
    endcase

    // Redirect overrides everything; a coincident ack or take is dropped.
    if (Redirect_I) begin
      PCWrite_O   = 1'b1;
      NPC_O       = RedirectAddr_I;
      accept      = 1'b0;
      take        = 1'b0;
      adel_set    = 1'b0;
      buserr_set  = 1'b0;
      tmo_cnt_nxt = 8'd0;
      state_nxt   = FETCH;
    end

    if (!Reset_I) begin
      IMemReq_O = 1'b0;
      PCWrite_O = 1'b0;
    end
  end

  always_ff @(posedge CLK_I) begin
    if (!Reset_I) begin
      state     <= IDLE;
      tmo_cnt   <= 8'd0;
      IR_O      <= 32'd0;
      PCPlus4_O <= 32'd0;
      IRValid_O <= 1'b0;
      AdEL_O    <= 1'b0;
      BusErr_O  <= 1'b0;
    end else begin
      state   <= state_nxt;
      tmo_cnt <= tmo_cnt_nxt;
      if (accept) begin
        IR_O      <= IMemData_I;
        PCPlus4_O <= pc_plus4;
        IRValid_O <= 1'b1;
      end else if (take || Redirect_I) begin
        IRValid_O <= 1'b0;
      end
      if (Redirect_I) begin
        AdEL_O   <= 1'b0;
        BusErr_O <= 1'b0;
      end else begin
        if (adel_set)   AdEL_O   <= 1'b1;
        if (buserr_set) BusErr_O <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch with a small PC-register model feeding PC_I.
module tb_instr_fetch;

  logic        CLK_I = 1'b0;
  logic        Reset_I;
  logic [31:0] PC_I;
  logic [31:0] IMemAddr_O;
  logic        IMemReq_O;
  logic        IMemAck_I;
  logic [31:0] IMemData_I;
  logic [31:0] IR_O;
  logic [31:0] PCPlus4_O;
  logic        IRValid_O;
  logic        IRTake_I;
  logic        Redirect_I;
  logic [31:0] RedirectAddr_I;
  logic [31:0] NPC_O;
  logic        PCWrite_O;
  logic        AdEL_O;
  logic        BusErr_O;

  logic        pc_load;
  logic [31:0] pc_load_val;
  logic [31:0] pc_reg;

  int tests = 0;
  int fails = 0;

  instr_fetch #(.TIMEOUT_CYCLES(8'd4)) dut (
    .CLK_I(CLK_I), .Reset_I(Reset_I), .PC_I(PC_I),
    .IMemAddr_O(IMemAddr_O), .IMemReq_O(IMemReq_O), .IMemAck_I(IMemAck_I),
    .IMemData_I(IMemData_I), .IR_O(IR_O), .PCPlus4_O(PCPlus4_O),
    .IRValid_O(IRValid_O), .IRTake_I(IRTake_I), .Redirect_I(Redirect_I),
    .RedirectAddr_I(RedirectAddr_I), .NPC_O(NPC_O), .PCWrite_O(PCWrite_O),
    .AdEL_O(AdEL_O), .BusErr_O(BusErr_O)
  );

  always #5 CLK_I = ~CLK_I;

  // PC register: bench load port has priority over the DUT write port.
  always @(posedge CLK_I) begin
    if (pc_load)        pc_reg <= pc_load_val;
    else if (PCWrite_O) pc_reg <= NPC_O;
  end
  assign PC_I = pc_reg;

  task automatic tick();
    @(posedge CLK_I);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    Reset_I = 1'b0; IMemAck_I = 1'b0; IMemData_I = 32'd0; IRTake_I = 1'b0;
    Redirect_I = 1'b0; RedirectAddr_I = 32'd0;
    pc_load = 1'b1; pc_load_val = 32'hBFC00000;

    // Reset for 3 cycles
    repeat (3) tick();
    check("rst_ir", IR_O, 32'd0);
    check("rst_pcp4", PCPlus4_O, 32'd0);
    check("rst_irvalid", IRValid_O, 1'b0);
    check("rst_adel", AdEL_O, 1'b0);
    check("rst_buserr", BusErr_O, 1'b0);
    check("rst_req", IMemReq_O, 1'b0);
    check("rst_pcwrite", PCWrite_O, 1'b0);
    Reset_I = 1'b1; pc_load = 1'b0;
    settle();
    check("idle_req", IMemReq_O, 1'b0);
    check("idle_pcwrite", PCWrite_O, 1'b0);

    // First fetch, ack two cycles after the request rises
    tick();
    check("f1_req_c0", IMemReq_O, 1'b1);
    check("f1_addr", IMemAddr_O, 32'hBFC00000);
    check("f1_pcwrite_c0", PCWrite_O, 1'b0);
    tick();
    check("f1_req_c1", IMemReq_O, 1'b1);
    check("f1_pcwrite_c1", PCWrite_O, 1'b0);
    tick();
    IMemAck_I = 1'b1; IMemData_I = 32'h3C1DA000;
    settle();
    check("f1_req_ack", IMemReq_O, 1'b1);
    check("f1_pcwrite_ack", PCWrite_O, 1'b1);
    check("f1_npc_ack", NPC_O, 32'hBFC00004);
    tick();
    IMemAck_I = 1'b0; IMemData_I = 32'h0;
    settle();
    check("f1_ir", IR_O, 32'h3C1DA000);
    check("f1_pcp4", PCPlus4_O, 32'hBFC00004);
    check("f1_irvalid", IRValid_O, 1'b1);
    check("f1_pcwrite_after", PCWrite_O, 1'b0);
    check("f1_pcreg", pc_reg, 32'hBFC00004);

    // Decode stalls for 5 cycles
    for (int i = 0; i < 5; i++) begin
      check("hold_irvalid", IRValid_O, 1'b1);
      check("hold_req", IMemReq_O, 1'b0);
      check("hold_ir", IR_O, 32'h3C1DA000);
      tick();
    end
    IRTake_I = 1'b1;
    settle();
    check("take_pcwrite", PCWrite_O, 1'b0);
    tick();
    IRTake_I = 1'b0;
    settle();
    check("take_irvalid", IRValid_O, 1'b0);
    check("take_req", IMemReq_O, 1'b1);
    check("take_addr", IMemAddr_O, 32'hBFC00004);

    // Misaligned PC
    pc_load = 1'b1; pc_load_val = 32'hBFC00002;
    tick();
    pc_load = 1'b0;
    settle();
    check("adel_req", IMemReq_O, 1'b0);
    check("adel_pcwrite", PCWrite_O, 1'b0);
    tick();
    check("adel_set", AdEL_O, 1'b1);
    check("fault_req", IMemReq_O, 1'b0);
    tick();
    check("adel_sticky", AdEL_O, 1'b1);
    check("fault_pcwrite", PCWrite_O, 1'b0);
    Redirect_I = 1'b1; RedirectAddr_I = 32'hBFC00380;
    settle();
    check("redir_pcwrite", PCWrite_O, 1'b1);
    check("redir_npc", NPC_O, 32'hBFC00380);
    tick();
    Redirect_I = 1'b0;
    settle();
    check("redir_adel_clr", AdEL_O, 1'b0);
    check("redir_req", IMemReq_O, 1'b1);
    check("redir_addr", IMemAddr_O, 32'hBFC00380);

    // Timeout after 4 un-acked request cycles
    for (int i = 0; i < 4; i++) begin
      check("tmo_req", IMemReq_O, 1'b1);
      check("tmo_pcwrite", PCWrite_O, 1'b0);
      check("tmo_buserr_pre", BusErr_O, 1'b0);
      tick();
    end
    check("tmo_buserr", BusErr_O, 1'b1);
    check("tmo_req_off", IMemReq_O, 1'b0);
    check("tmo_pcwrite_off", PCWrite_O, 1'b0);
    tick();
    check("tmo_buserr_sticky", BusErr_O, 1'b1);
    check("tmo_pcreg", pc_reg, 32'hBFC00380);

    // Leave FAULT, then redirect coinciding with an ack
    Redirect_I = 1'b1; RedirectAddr_I = 32'h80000000;
    tick();
    Redirect_I = 1'b0;
    settle();
    check("r2_buserr_clr", BusErr_O, 1'b0);
    check("r2_addr", IMemAddr_O, 32'h80000000);
    IMemAck_I = 1'b1; IMemData_I = 32'hDEADBEEF;
    Redirect_I = 1'b1; RedirectAddr_I = 32'h80000180;
    settle();
    check("ra_pcwrite", PCWrite_O, 1'b1);
    check("ra_npc", NPC_O, 32'h80000180);
    tick();
    IMemAck_I = 1'b0; IMemData_I = 32'h0; Redirect_I = 1'b0;
    settle();
    check("ra_ir_kept", IR_O, 32'h3C1DA000);
    check("ra_pcp4_kept", PCPlus4_O, 32'hBFC00004);
    check("ra_irvalid", IRValid_O, 1'b0);
    check("ra_req", IMemReq_O, 1'b1);
    check("ra_addr", IMemAddr_O, 32'h80000180);

    // Reset in the middle of a fetch wait
    tick();
    Reset_I = 1'b0; IMemAck_I = 1'b1; IMemData_I = 32'h12345678;
    settle();
    check("mrst_pcwrite", PCWrite_O, 1'b0);
    tick();
    check("mrst_ir", IR_O, 32'd0);
    check("mrst_pcp4", PCPlus4_O, 32'd0);
    check("mrst_irvalid", IRValid_O, 1'b0);
    check("mrst_req", IMemReq_O, 1'b0);
    Reset_I = 1'b1;
    settle();
    check("mrst_idle_req", IMemReq_O, 1'b0);
    check("mrst_idle_pcwrite", PCWrite_O, 1'b0);
    tick();
    IMemAck_I = 1'b0; IMemData_I = 32'h0;
    settle();
    check("mrst_no_stale_ir", IR_O, 32'd0);
    check("mrst_no_stale_valid", IRValid_O, 1'b0);
    check("mrst_req_resume", IMemReq_O, 1'b1);
    check("mrst_addr", IMemAddr_O, 32'h80000180);

    // PC+4 wraps modulo 2^32
    pc_load = 1'b1; pc_load_val = 32'hFFFFFFFC;
    tick();
    pc_load = 1'b0;
    IMemAck_I = 1'b1; IMemData_I = 32'h00000013;
    settle();
    check("wrap_pcwrite", PCWrite_O, 1'b1);
    check("wrap_npc", NPC_O, 32'h00000000);
    tick();
    IMemAck_I = 1'b0;
    settle();
    check("wrap_ir", IR_O, 32'h00000013);
    check("wrap_pcp4", PCPlus4_O, 32'h00000000);
    check("wrap_irvalid", IRValid_O, 1'b1);
    check("wrap_pcreg", pc_reg, 32'h00000000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
